// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared encodings for the datapath instruction sequencer
package datapath_ctrl_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_RD  = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } instr_cls_e;

    // ALU operation codes driven onto ALUop
    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    // Shifter codes driven onto shift
    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    // Opcode / op field values
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// rtl/datapath_ctrl_instr_dec.sv - combinational field split and class decode of the instruction register
module instr_dec
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] imm_ext,
    output instr_cls_e  cls
);

    logic [2:0] opcode;
    logic [1:0] op;

    // Field extraction and sign-extended immediate
    always_comb begin
        opcode  = ir[15:13];
        op      = ir[12:11];
        rn      = ir[10:8];
        rd      = ir[7:5];
        sh      = ir[4:3];
        rm      = ir[2:0];
        imm_ext = {{8{ir[7]}}, ir[7:0]};
    end

    // Map opcode/op to an instruction class; anything else is CLS_NONE
    always_comb begin
        cls = CLS_NONE;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - Moore sequencer that steps the lab datapath through one instruction
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_ir,
    input  logic [15:0] instr,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm_ext;
    instr_cls_e  cls;

    instr_dec u_dec (
        .ir      (ir_q),
        .rn      (rn),
        .rd      (rd),
        .rm      (rm),
        .sh      (sh),
        .imm_ext (imm_ext),
        .cls     (cls)
    );

    // State and instruction register; reset abandons any partial instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only accepts a new word while idle; requests elsewhere are dropped
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load_ir) ir_d = instr;
    end

    // Next-state sequencing
    always_comb begin
        state_d = S_WAIT;
        case (state_q)
            S_WAIT:      state_d = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                     state_d = S_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:            state_d = S_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:       state_d = S_GET_A;
                    default:                         state_d = S_WAIT;
                endcase
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE_RD;
            S_WRITE_RD:  state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Control bundle decoded from state and IR only (pure Moore)
    always_comb begin
        w           = 1'b0;
        readnum     = 3'd0;
        writenum    = 3'd0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        write       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        vsel        = 1'b0;
        shift       = SH_NONE;
        ALUop       = ALU_ADD;
        datapath_in = imm_ext;
        case (state_q)
            S_WAIT:  w = 1'b1;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                // MOV reg and MVN use a zero A operand so the ALU passes B through
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                case (cls)
                    CLS_CMP: ALUop = ALU_SUB;
                    CLS_AND: ALUop = ALU_AND;
                    CLS_MVN: ALUop = ALU_NOTB;
                    default: ALUop = ALU_ADD;
                endcase
                if (cls == CLS_CMP) loads = 1'b1;
                else                loadc = 1'b1;
            end
            S_WRITE_RD: begin
                writenum = rd;
                write    = 1'b1;
            end
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_ir;
    logic [15:0] instr;
    logic        s;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic        loada, loadb, loadc, loads, write;
    logic        asel, bsel, vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    datapath_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load_ir     (load_ir),
        .instr       (instr),
        .s           (s),
        .w           (w),
        .readnum     (readnum),
        .writenum    (writenum),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .write       (write),
        .asel        (asel),
        .bsel        (bsel),
        .vsel        (vsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in)
    );

    // {w,readnum,writenum,loada,loadb,loadc,loads,write,asel,bsel,vsel,shift,ALUop}
    logic [18:0] bundle;
    assign bundle = {w, readnum, writenum, loada, loadb, loadc, loads, write,
                     asel, bsel, vsel, shift, ALUop};

    function automatic logic [18:0] cb(input logic iw, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic la, input logic lb, input logic lc, input logic ls,
                                       input logic wr, input logic as, input logic vs,
                                       input logic [1:0] sh, input logic [1:0] op);
        return {iw, rn, wn, la, lb, lc, ls, wr, as, 1'b0, vs, sh, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bundles for the states visited
    localparam logic [18:0] B_WAIT = 19'h40000;
    localparam logic [18:0] B_IDLE = 19'h00000;

    initial begin
        reset = 1'b1; load_ir = 1'b0; instr = 16'h0000; s = 1'b0;
        #12;
        check("reset_bundle", {13'd0, bundle}, {13'd0, B_WAIT});
        check("reset_dpin", {16'd0, datapath_in}, 32'h0);
        step();
        reset = 1'b0;
        step();
        check("idle_wait", {13'd0, bundle}, {13'd0, B_WAIT});

        // MOV R2,#-9 : load, then start
        instr = 16'hD2F7; load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        check("movi_ir_dpin", {16'd0, datapath_in}, 32'h0000FFF7);
        check("movi_wait", {13'd0, bundle}, {13'd0, B_WAIT});
        s = 1'b1;
        step();
        s = 1'b0;
        check("movi_decode", {13'd0, bundle}, {13'd0, B_IDLE});
        step();
        check("movi_write_imm", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd2, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00)});
        check("movi_dpin", {16'd0, datapath_in}, 32'h0000FFF7);
        step();
        check("movi_back_e2", {13'd0, bundle}, {13'd0, B_WAIT});

        // ADD R3,R1,R2,LSL with load_ir and s together
        instr = 16'hA16A; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        check("add_decode", {13'd0, bundle}, {13'd0, B_IDLE});
        step();
        check("add_get_a", {13'd0, bundle},
              {13'd0, cb(0, 3'd1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        check("add_get_b", {13'd0, bundle},
              {13'd0, cb(0, 3'd2, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        check("add_exec", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00)});
        step();
        check("add_write_rd", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd3, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)});
        step();
        check("add_back_e5", {13'd0, bundle}, {13'd0, B_WAIT});

        // CMP R1,R2
        instr = 16'hA902; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        step();
        check("cmp_get_a", {13'd0, bundle},
              {13'd0, cb(0, 3'd1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        check("cmp_get_b", {13'd0, bundle},
              {13'd0, cb(0, 3'd2, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        check("cmp_exec", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01)});
        step();
        check("cmp_back_e4", {13'd0, bundle}, {13'd0, B_WAIT});

        // MVN R4,R0
        instr = 16'hB880; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        step();
        check("mvn_get_b", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        step();
        check("mvn_exec", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b11)});
        step();
        check("mvn_write_rd", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)});
        step();
        check("mvn_back_e4", {13'd0, bundle}, {13'd0, B_WAIT});

        // Unsupported 0000
        instr = 16'h0000; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        check("unsup_decode", {13'd0, bundle}, {13'd0, B_IDLE});
        step();
        check("unsup_back_e1", {13'd0, bundle}, {13'd0, B_WAIT});

        // MOV R5,R3,LSR with s/load_ir poked during GET_B
        instr = 16'hC0B3; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        step();
        check("movr_get_b", {13'd0, bundle},
              {13'd0, cb(0, 3'd3, 3'd0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)});
        instr = 16'hD2F7; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        check("movr_exec", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00)});
        check("movr_ir_kept", {16'd0, datapath_in}, 32'h0000FFB3);
        step();
        check("movr_write_rd", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd5, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)});
        step();
        check("movr_back", {13'd0, bundle}, {13'd0, B_WAIT});
        step();
        check("movr_no_restart", {13'd0, bundle}, {13'd0, B_WAIT});
        check("movr_ir_final", {16'd0, datapath_in}, 32'h0000FFB3);

        // Reset in the middle of ADD's EXEC
        instr = 16'hA16A; load_ir = 1'b1; s = 1'b1;
        step();
        load_ir = 1'b0; s = 1'b0;
        step();
        step();
        step();
        check("rst_pre_exec", {13'd0, bundle},
              {13'd0, cb(0, 3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00)});
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_bundle", {13'd0, bundle}, {13'd0, B_WAIT});
        check("rst_mid_dpin", {16'd0, datapath_in}, 32'h0);
        #1;
        reset = 1'b0;
        s = 1'b1;
        step();
        s = 1'b0;
        check("rst_s_decode", {13'd0, bundle}, {13'd0, B_IDLE});
        step();
        check("rst_s_ir0_back", {13'd0, bundle}, {13'd0, B_WAIT});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction-sequencing controller that drives the lab datapath's control bundle automatically, replacing manual switch entry of the same signals. It holds one 16-bit instruction, decodes it, and steps the datapath through register-read, execute and writeback cycles. It produces `datapath_in` for immediate moves and raises `w` when it can accept the next instruction. The datapath's own registers, ALU and status flag live in the existing datapath. This block only sequences them.

## Interface
- No parameters. Widths are fixed by the datapath control bundle.
- `clk` in 1: rising-edge clock, shared with the datapath.
- `reset` in 1: asynchronous, active-high. Forces `WAIT` and clears the instruction register (IR).
- `load_ir` in 1: capture `instr` into IR. Honoured only in `WAIT`.
- `instr` in 16: instruction word.
- `s` in 1: start execution of IR. Honoured only in `WAIT`.
- `w` out 1: 1 in `WAIT` only.
- `readnum`, `writenum` out 3 each: register-file read and write indices.
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1 each: load enables for A, B, C, status, and register-file write.
- `asel`, `bsel`, `vsel` out 1 each:
  - `asel=1` selects zero for the A operand.
  - `vsel=1` writes `datapath_in`; `vsel=0` writes C.
  - `bsel` is always 0.
- `shift` out 2: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- `ALUop` out 2: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
- `datapath_in` out 16: `{{8{IR[7]}},IR[7:0]}` (sign-extended imm8). Always driven.

## Operation
- IR fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0]
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
- Any other opcode/op returns to `WAIT` from `DECODE` with no datapath side effects.
- Moore FSM. Every control output not listed for a state is 0 (`readnum`/`writenum`/`shift`/`ALUop` also 0).
  - `WAIT`: `w=1`. If `s` → `DECODE`, else stay.
  - `DECODE`:
    - MOV imm → `WRITE_IMM`
    - MOV reg or MVN → `GET_B`
    - ADD/CMP/AND → `GET_A`
    - unsupported → `WAIT`
  - `GET_A`: `readnum=Rn`, `loada=1` → `GET_B`.
  - `GET_B`: `readnum=Rm`, `loadb=1` → `EXEC`.
  - `EXEC`: `shift=sh`.
    - `asel=1` for MOV reg / MVN, else 0.
    - `ALUop`: ADD→00, CMP→01, AND→10, MVN→11, MOV reg→00 (0+B).
    - CMP: `loads=1`, `loadc=0`, then → `WAIT`.
    - All others: `loadc=1`, then → `WRITE_RD`.
  - `WRITE_RD`: `writenum=Rd`, `vsel=0`, `write=1` → `WAIT`.
  - `WRITE_IMM`: `writenum=Rn`, `vsel=1`, `write=1` → `WAIT`.
- IR update: registered; loads on an edge where state=`WAIT` and `load_ir=1`. Holds otherwise.
- `load_ir` and `s` together in `WAIT`: IR takes the new `instr`, and `DECODE` (next cycle) uses the new value.
- `s`/`load_ir` outside `WAIT`: ignored, with no queuing.

## Timing
- Count cycles from the edge that samples `s=1` in `WAIT` as edge 0. "Back in `WAIT`" means `w=1` after the listed edge:
  - MOV imm: `DECODE`, `WRITE_IMM`; back in `WAIT` after edge 2.
  - MOV reg / MVN: `DECODE`, `GET_B`, `EXEC`, `WRITE_RD`; back after edge 4.
  - ADD/AND: `DECODE`, `GET_A`, `GET_B`, `EXEC`, `WRITE_RD`; back after edge 5.
  - CMP: `DECODE`, `GET_A`, `GET_B`, `EXEC`; back after edge 4.
  - Unsupported: back after edge 1.
- Outputs are combinational from state and IR only, with no path from `s`/`load_ir`/`instr`. The datapath captures each enable on the edge that ends the state.
- Reset (async, any state, mid-instruction included):
  - state `WAIT`, IR=0
  - `w=1`, all enables 0, `datapath_in=0` immediately
  - partial instruction abandoned
- Reset deasserting with `s=1`: normal `WAIT` sampling on the next edge.

## Structure
- Shared package holds:
  - state encoding (7 states, 3-bit)
  - opcode/op constants
  - ALUop constants
  - shift constants
- One combinational sub-module, `instr_dec`, is natural. It maps IR to Rn/Rd/Rm/sh, the sign-extended imm8, and an instruction-class code.
- FSM next-state logic, IR register and output decode stay in `datapath_ctrl`.

## Test plan
- Reset mid-`EXEC` of ADD → immediately `w=1`, `loadc=0`, `write=0`; IR reads 0.
- Load 16'hD2F7 (MOV R2,#-9), pulse `s` → after edge 1: `write=1`, `writenum=2`, `vsel=1`, `datapath_in=16'hFFF7`; `w=1` after edge 2.
- Load 16'hA16A (ADD R3,R1,R2,LSL) → `GET_A` `readnum=1`/`loada`; `GET_B` `readnum=2`/`loadb`; `EXEC` `shift=01`, `ALUop=00`, `loadc`; `WRITE_RD` `writenum=3`; `w` after edge 5.
- Load 16'hA902 (CMP R1,R2) → `EXEC` `ALUop=01`, `loads=1`, `loadc=0`; no `write` cycle; `w=1` after edge 4.
- Load 16'hB880 (MVN R4,R0) → `EXEC` `asel=1`, `ALUop=11`; `WRITE_RD` `writenum=4`. Unsupported 16'h0000 → only `DECODE`, then `w=1` after edge 1.
- `s` and `load_ir` pulsed during `GET_B` with a new `instr` → IR and sequence unchanged; no restart after return to `WAIT`.
